// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver.
// Scans DIGITS digits of a frame-synchronous snapshot of `value`, pages through
// values wider than one screen with a debounced button, and can blank leading zeros.
module ssd_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int DATA_W       = 32,
    parameter int REFRESH_DIV  = 100000,
    parameter int DEBOUNCE_CYC = 500000,
    localparam int PAGES       = DATA_W / (4 * DIGITS),
    localparam int PW          = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] value,
    input  logic              page_btn,
    input  logic              blank_lz,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [PW-1:0]     page
);

    localparam int NIB = DATA_W / 4;
    localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW  = $clog2(REFRESH_DIV);
    localparam int BW  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] D_LAST    = DW'(DIGITS - 1);
    localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);
    localparam logic [BW-1:0] DB_LAST   = BW'(DEBOUNCE_CYC - 1);

    logic [CW-1:0]     cnt;
    logic [DW-1:0]     d;
    logic [DATA_W-1:0] shadow;
    logic              load_pending;
    logic              tick;
    logic              frame_end;

    logic              sync_1;
    logic              sync_2;
    logic [BW-1:0]     db_cnt;
    logic              db_level;
    logic              db_level_q;
    logic              page_step;

    logic [NW-1:0]     nib_idx;
    logic [DATA_W-1:0] shifted;
    logic [3:0]        nibble;
    logic              blank;
    logic [6:0]        seg_dec;
    logic [DIGITS-1:0] an_dec;
    logic              dp_dec;

    assign tick      = (cnt == CNT_LAST);
    assign frame_end = tick && (d == D_LAST);
    assign page_step = db_level & ~db_level_q;

    // Prescaler, digit index and the snapshot taken at each frame boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            d            <= '0;
            shadow       <= '0;
            load_pending <= 1'b1;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                d <= (d == D_LAST) ? '0 : d + 1'b1;
            end
            if (load_pending || frame_end) begin
                shadow <= value;
            end
            load_pending <= 1'b0;
        end
    end

    // Button synchroniser and debouncer; the counter restarts whenever the
    // synchronised level falls back to the accepted level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            db_cnt     <= '0;
            db_level   <= 1'b0;
            db_level_q <= 1'b0;
        end else begin
            sync_1     <= page_btn;
            sync_2     <= sync_1;
            db_level_q <= db_level;
            if (sync_2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync_2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Page index advances on each accepted press, wrapping at PAGES
    always_ff @(posedge clk) begin
        if (reset) begin
            page <= '0;
        end else if (page_step) begin
            page <= (page == PAGE_LAST) ? '0 : page + 1'b1;
        end
    end

    // Select the nibble for the current digit, decide blanking and decode it
    always_comb begin
        nib_idx = NW'(page) * NW'(DIGITS) + NW'(d);
        shifted = shadow >> {nib_idx, 2'b00};
        nibble  = shifted[3:0];
        blank   = blank_lz && (nib_idx != '0) && (shifted == '0);
        an_dec  = ~(DIGITS'(1) << d);
        dp_dec  = ~((d == D_LAST) && (page != '0));
        seg_dec = 7'h7F;
        case (nibble)
            4'h0: seg_dec = 7'h40;
            4'h1: seg_dec = 7'h79;
            4'h2: seg_dec = 7'h24;
            4'h3: seg_dec = 7'h30;
            4'h4: seg_dec = 7'h19;
            4'h5: seg_dec = 7'h12;
            4'h6: seg_dec = 7'h02;
            4'h7: seg_dec = 7'h78;
            4'h8: seg_dec = 7'h00;
            4'h9: seg_dec = 7'h10;
            4'hA: seg_dec = 7'h08;
            4'hB: seg_dec = 7'h03;
            4'hC: seg_dec = 7'h46;
            4'hD: seg_dec = 7'h21;
            4'hE: seg_dec = 7'h06;
            4'hF: seg_dec = 7'h0E;
            default: seg_dec = 7'h7F;
        endcase
    end

    // Registered digit outputs; a blanked digit turns everything off
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (blank) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_dec;
            seg <= seg_dec;
            dp  <= dp_dec;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: cycle model built from the display rules plus
// directed scenarios with hand-computed literal expectations.
module tb_ssd_scan_driver;

    localparam int DIG = 4;
    localparam int DW  = 32;
    localparam int RD  = 4;
    localparam int DC  = 3;
    localparam int NPG = DW / (4 * DIG);

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] value;
    logic        page_btn;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [0:0]  page;

    int vectors = 0;
    int miscompares = 0;

    ssd_scan_driver #(
        .DIGITS(DIG), .DATA_W(DW), .REFRESH_DIV(RD), .DEBOUNCE_CYC(DC)
    ) dut (
        .clk(clk), .reset(reset), .value(value), .page_btn(page_btn),
        .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp), .page(page)
    );

    always #5 clk = ~clk;

    logic [6:0] hex7 [16];
    initial begin
        hex7[0]  = 7'h40; hex7[1]  = 7'h79; hex7[2]  = 7'h24; hex7[3]  = 7'h30;
        hex7[4]  = 7'h19; hex7[5]  = 7'h12; hex7[6]  = 7'h02; hex7[7]  = 7'h78;
        hex7[8]  = 7'h00; hex7[9]  = 7'h10; hex7[10] = 7'h08; hex7[11] = 7'h03;
        hex7[12] = 7'h46; hex7[13] = 7'h21; hex7[14] = 7'h06; hex7[15] = 7'h0E;
    end

    // ---------------- behavioural model ----------------
    bit          m_valid = 0;
    int          m_n;
    logic [31:0] m_shadow;
    int          m_page;
    bit          h1, h2, deb, rise_pend;
    bit          win[$];
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [0:0]  exp_page;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1; m_n = 0; m_shadow = '0; m_page = 0;
            h1 = 0; h2 = 0; deb = 0; rise_pend = 0; win.delete();
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
        end else if (m_valid) begin
            int  dd, idx;
            bit  s, all_diff;
            logic [31:0] upper;
            dd    = (m_n / RD) % DIG;
            idx   = m_page * DIG + dd;
            upper = m_shadow >> (4 * idx);
            if (blank_lz && idx > 0 && upper == 0) begin
                exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end else begin
                exp_an  = 4'hF ^ (4'h1 << dd);
                exp_seg = hex7[upper[3:0]];
                exp_dp  = !(dd == DIG - 1 && m_page != 0);
            end
            if (m_n == 0 || (m_n + 1) % (RD * DIG) == 0) m_shadow = value;
            if (rise_pend) m_page = (m_page + 1) % NPG;
            rise_pend = 0;
            s = h2; h2 = h1; h1 = page_btn;
            win.push_back(s);
            if (win.size() > DC) void'(win.pop_front());
            if (win.size() == DC) begin
                all_diff = 1;
                foreach (win[k]) if (win[k] == deb) all_diff = 0;
                if (all_diff) begin
                    deb = !deb;
                    rise_pend = deb;
                end
            end
            m_n++;
        end
        exp_page = 1'(m_page);
    end

    // ---------------- literal-check mailbox ----------------
    int         lit_req = 0;
    int         lit_ack = 0;
    string      lit_name;
    int         lit_kind;
    logic [3:0] lit_an;
    logic [6:0] lit_seg;
    logic       lit_dp;
    logic [0:0] lit_page;

    // Single compare process: model check every cycle plus queued literal checks
    always @(negedge clk) begin
        if (m_valid) begin
            vectors++;
            if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || page !== exp_page) begin
                miscompares++;
                $display("FAIL model_cycle t=%0t: got an=%b seg=%h dp=%b page=%0d, expected an=%b seg=%h dp=%b page=%0d",
                         $time, an, seg, dp, page, exp_an, exp_seg, exp_dp, exp_page);
            end
        end
        if (lit_req != lit_ack) begin
            lit_ack = lit_req;
            vectors++;
            case (lit_kind)
                0: if (an !== lit_an || seg !== lit_seg || dp !== lit_dp) begin
                       miscompares++;
                       $display("FAIL %s: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                                lit_name, an, seg, dp, lit_an, lit_seg, lit_dp);
                   end
                1: if (page !== lit_page) begin
                       miscompares++;
                       $display("FAIL %s: got page=%0d, expected page=%0d", lit_name, page, lit_page);
                   end
                1+1: if (lit_kind == 2) begin
                       miscompares++;
                       $display("FAIL %s: timed out waiting for an=%b, last an=%b", lit_name, lit_an, an);
                   end
                default: ;
            endcase
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic post(string nm, int kind, logic [3:0] a, logic [6:0] s, logic p, logic [0:0] pg);
        lit_name = nm; lit_kind = kind;
        lit_an = a; lit_seg = s; lit_dp = p; lit_page = pg;
        lit_req++;
        @(negedge clk);
        #1;
    endtask

    task automatic expect_out(string nm, logic [3:0] a, logic [6:0] s, logic p);
        post(nm, 0, a, s, p, 1'b0);
    endtask

    task automatic expect_page(string nm, logic [0:0] pg);
        post(nm, 1, 4'h0, 7'h0, 1'b0, pg);
    endtask

    task automatic wait_digit(string nm, logic [3:0] target, int budget);
        bit found = 0;
        for (int i = 0; i < budget; i++) begin
            if (an === target) begin
                found = 1;
                break;
            end
            step();
        end
        if (!found) post(nm, 2, target, 7'h0, 1'b0, 1'b0);
    endtask

    task automatic press(int len);
        page_btn = 1'b1;
        step(len);
        page_btn = 1'b0;
    endtask

    initial begin
        reset = 1'b1; value = 32'h0000_1234; page_btn = 1'b0; blank_lz = 1'b0;
        step(3);

        // basic scan
        reset = 1'b0;
        step(2);
        expect_out("scan_d0", 4'b1110, 7'h19, 1'b1);
        step(3);
        expect_out("scan_d1", 4'b1101, 7'h30, 1'b1);
        step(4);
        expect_out("scan_d2", 4'b1011, 7'h24, 1'b1);
        step(4);
        expect_out("scan_d3", 4'b0111, 7'h79, 1'b1);
        step(4);
        expect_out("scan_wrap", 4'b1110, 7'h19, 1'b1);
        step(8);

        // paging
        value = 32'hABCD_1234;
        reset = 1'b1; step(1); reset = 1'b0;
        step(2);
        press(6);
        step(10);
        expect_page("page_first_press", 1'b1);
        wait_digit("wait_p1_d3", 4'b0111, 20);
        expect_out("page1_d3", 4'b0111, 7'h08, 1'b0);
        wait_digit("wait_p1_d0", 4'b1110, 20);
        expect_out("page1_d0", 4'b1110, 7'h21, 1'b1);
        press(6);
        step(10);
        expect_page("page_second_press", 1'b0);
        press(2);
        step(12);
        expect_page("page_short_press", 1'b0);

        // blanking
        blank_lz = 1'b1; value = 32'h0000_0050;
        reset = 1'b1; step(1); reset = 1'b0;
        step(2);
        expect_out("blank_d0", 4'b1110, 7'h40, 1'b1);
        step(4);
        expect_out("blank_d1", 4'b1101, 7'h12, 1'b1);
        step(4);
        expect_out("blank_d2", 4'b1111, 7'h7F, 1'b1);
        value = 32'h0;
        step(8);
        expect_out("zero_d0", 4'b1110, 7'h40, 1'b1);
        step(4);
        expect_out("zero_d1", 4'b1111, 7'h7F, 1'b1);
        value = 32'h0000_FFFF;
        press(6);
        step(16);
        expect_page("blank_page1", 1'b1);
        for (int i = 0; i < 16; i++) begin
            expect_out("blank_all_p1", 4'b1111, 7'h7F, 1'b1);
            step();
        end

        // tear-free snapshot
        blank_lz = 1'b0; value = 32'h0000_1111;
        reset = 1'b1; step(1); reset = 1'b0;
        step(5);
        value = 32'h0000_2222;
        step(1);
        expect_out("tear_d1", 4'b1101, 7'h79, 1'b1);
        step(4);
        expect_out("tear_d2", 4'b1011, 7'h79, 1'b1);
        step(4);
        expect_out("tear_d3", 4'b0111, 7'h79, 1'b1);
        step(4);
        expect_out("next_d0", 4'b1110, 7'h24, 1'b1);
        step(4);
        expect_out("next_d1", 4'b1101, 7'h24, 1'b1);

        // reset mid-operation
        press(6);
        step(6);
        wait_digit("wait_d2", 4'b1011, 20);
        expect_page("pre_reset_page", 1'b1);
        reset = 1'b1;
        step(1);
        expect_out("reset_outputs", 4'b1111, 7'h7F, 1'b1);
        expect_page("reset_page", 1'b0);
        reset = 1'b0;
        step(2);
        expect_out("after_reset_d0", 4'b1110, 7'h24, 1'b1);
        step(6);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
